// File: rtl/row_access_ctrl.sv
// Row-access sequencer ahead of the 5-to-32 row decoder: per row it runs
// precharge, one settle cycle, then a wordline window, and pulses done at the end.
module row_access_ctrl #(
  parameter int unsigned PRE_CYC = 1,
  parameter int unsigned WL_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_addr,
  input  logic [4:0] req_len,
  input  logic       req_we,
  output logic [4:0] A,
  output logic       pre_en,
  output logic       wl_en,
  output logic       we_out,
  output logic       busy,
  output logic       done
);

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so req_valid and
  // the request fields are ignored at every other edge.

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRECH  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_WL     = 2'd3;

  // Phase counters are loaded with the last index and count down to zero.
  localparam logic [3:0] PRE_LAST = 4'(PRE_CYC - 1);
  localparam logic [3:0] WL_LAST  = 4'(WL_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] rem_q, rem_d;
  logic [4:0] a_q, a_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic       pre_en_q, pre_en_d;
  logic       wl_en_q, wl_en_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    a_d     = a_q;
    we_d    = we_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_PRECH;
          cnt_d   = PRE_LAST;
          rem_d   = req_len;
          a_d     = req_addr;
          we_d    = req_we;
        end
      end
      ST_PRECH: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SETTLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_SETTLE: begin
        state_d = ST_WL;
        cnt_d   = WL_LAST;
      end
      ST_WL: begin
        if (cnt_q == 4'd0) begin
          if (rem_q == 5'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            // Next row: the 5-bit add wraps 31 to 0.
            state_d = ST_PRECH;
            cnt_d   = PRE_LAST;
            rem_d   = rem_q - 5'd1;
            a_d     = a_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Enables are decoded from the next state so every output is a flop.
  always_comb begin
    pre_en_d = (state_d == ST_PRECH);
    wl_en_d  = (state_d == ST_WL);
    busy_d   = (state_d != ST_IDLE);
    ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      rem_q    <= 5'd0;
      a_q      <= 5'd0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      pre_en_q <= 1'b0;
      wl_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      a_q      <= a_d;
      we_q     <= we_d;
      done_q   <= done_d;
      pre_en_q <= pre_en_d;
      wl_en_q  <= wl_en_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign A         = a_q;
  assign pre_en    = pre_en_q;
  assign wl_en     = wl_en_q;
  assign we_out    = we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = ready_q;

  // Invariants the decoder relies on.
  a_enables_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(pre_en_q && wl_en_q));

  a_addr_moves_legally: assert property (@(posedge clk) disable iff (!rst_n)
    (a_d != a_q) |-> ((state_q == ST_IDLE) || (state_q == ST_WL && state_d == ST_PRECH)));

  a_ready_is_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    ready_q == !busy_q);

  a_done_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    done_q |-> !busy_q);

endmodule

// File: doc/row_access_ctrl.md
# row_access_ctrl

Row-access sequencer that sits directly upstream of the 5-to-32 row `decoder`. It accepts a row request (start address, burst length, write flag) over a valid/ready handshake and drives the decoder's 5-bit address `A`. For each row it then runs a precharge / address-settle / wordline-enable sequence, so that the one-hot decoder output `Z` is sampled only inside a clean wordline window. A `done` pulse marks the end of each request.

## Interface
Parameters:
- `PRE_CYC`, default 1: precharge cycles per row. Legal range 1..15.
- `WL_CYC`, default 2: wordline-enable cycles per row. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept; high only in IDLE.
- `req_addr`  in  5  first row address.
- `req_len`  in  5  rows minus one. 0 means 1 row; 31 means 32 rows.
- `req_we`  in  1  write access flag.
- `A`  out  5  row address to `decoder`.
- `pre_en`  out  1  bitline precharge enable.
- `wl_en`  out  1  wordline enable; qualifies decoder `Z`.
- `we_out`  out  1  latched `req_we`; valid while busy.
- `busy`  out  1  request in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse after the last row of a request completes.

## Operation
- States: IDLE, PRECH, SETTLE, WL. All outputs are registered.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready` at a rising edge, latch `req_addr` into `A`, `req_len` into the remaining-row counter, and `req_we` into `we_out`. Go to PRECH.
- PRECH: `pre_en`=1 for `PRE_CYC` cycles, then go to SETTLE.
- SETTLE: exactly 1 cycle with all enables low. This gives decoder propagation time with `A` stable.
- WL: `wl_en`=1 for `WL_CYC` cycles. At the end of the window:
  - If remaining = 0: go to IDLE.
  - Else: decrement remaining, set `A` ← `A`+1 mod 32 (31 wraps to 0), go to PRECH.
- `done`=1 for exactly the first IDLE cycle after a request's final WL cycle.
- `req_ready` is also high in that cycle, so a back-to-back accept is legal there.
- `req_valid` is ignored while busy. Input values are don't-care when not accepted.
- Invariants:
  - `pre_en` and `wl_en` are never high together.
  - `A` changes only on an accept edge or on a WL→PRECH edge, so never during SETTLE or WL.
  - In IDLE, `A` holds its last value.
- `we_out` holds its value in IDLE until the next accept.
- Per-row cost is `PRE_CYC`+1+`WL_CYC` cycles. A request costs (`req_len`+1)×(`PRE_CYC`+1+`WL_CYC`) cycles of busy.

## Timing
- Reset (`rst_n`=0), applied asynchronously:
  - State = IDLE.
  - `A`=0, `pre_en`=0, `wl_en`=0, `we_out`=0, `busy`=0, `done`=0, `req_ready`=1.
- Reset mid-operation:
  - All enables drop immediately, without waiting for a clock edge.
  - No `done` is produced; the request is discarded.
- Latency:
  - With the accept at edge 0, `A` is valid and `pre_en` is high from cycle 1.
  - `wl_en` first rises at cycle `PRE_CYC`+2.
- Defaults (PRE=1, WL=2), one-row request:
  - cycle 1: PRECH.
  - cycle 2: SETTLE.
  - cycles 3–4: WL.
  - cycle 5: IDLE with `done`=1.
- Decoder `Z` must equal 1<<`A` in every `wl_en` cycle.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `A`=0, all enables and `done`=0, `req_ready`=1, `busy`=0, with no clock edge needed.
- Single row (defaults): addr=7, len=0, we=1, accepted at edge 0 → `A`=7 from cycle 1; `pre_en` at cycle 1; `wl_en` at cycles 3–4; `done` and `req_ready` at cycle 5; `we_out`=1 during cycles 1–4.
- Wrap burst: addr=30, len=3 → `A` = 30, 31, 0, 1, 4 cycles each; 8 `wl_en` cycles total; `done` at cycle 17; `Z` = 1<<30, 1<<31, 1, 2 during the respective WL windows.
- Handshake: `req_valid` held high through a len=1 request → no accept until the `done` cycle; the second request is accepted on that edge and its `pre_en` rises the next cycle.
- Reset mid-WL: drop `rst_n` on the second WL cycle of a len=2 burst → `wl_en` falls immediately; `done` never pulses; after release, `req_ready`=1 and `A`=0.
- Full sweep with `decoder` attached, addr=0, len=31 → `Z`=1<<i in each WL window, i = 0..31; 128 busy cycles; `done` at cycle 129; `pre_en` and `wl_en` never high together.
